pulpemu_rst_gen: RTL

FPGA-emulation reset generator that sits directly upstream of the PULP SoC's active-low `pad_reset_n` input in the pulpemu top level. It combines three reset sources into one glitch-free, stretched, `ref_clk`-synchronous release:

- the board push-button (`pad_reset`)
- clock-generator lock status
- a soft reset request from a debug/VIO source

It replaces the bare inversion of the button in the emulation top and counts reset episodes that were not caused by the button.

---
 rtl/pulpemu_rst_pkg.sv | 16 +
 rtl/pulpemu_rst_sync.sv | 23 ++
 rtl/pulpemu_rst_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/pulpemu_rst_pkg.sv
// Shared types and sizing helpers for the pulpemu reset generator.
package pulpemu_rst_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } rst_state_e;

  function automatic int stretch_cnt_w(input int hold_cycles);
    return ($clog2(hold_cycles) < 1) ? 1 : $clog2(hold_cycles);
  endfunction

  localparam int STRETCH_CNT_W = stretch_cnt_w(16);

endpackage

// File: rtl/pulpemu_rst_sync.sv
// N-flop async-clear single-bit synchronizer; output reads 0 while cleared.
module pulpemu_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulpemu_rst_gen.sv
// Merges button, clock lock and soft request into one stretched, ref_clk-synchronous
// active-low SoC reset, counting every non-button reset episode.
module pulpemu_rst_gen
  import pulpemu_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             ref_clk,
  input  logic             pad_reset,
  input  logic             clk_locked_i,
  input  logic             soft_rst_req_i,
  output logic             pad_reset_n_o,
  output logic             rst_active_o,
  output logic [CNT_W-1:0] rst_count_o
);

  localparam int SCW = stretch_cnt_w(HOLD_CYCLES);
  localparam logic [SCW-1:0] CNT_LAST = SCW'(HOLD_CYCLES - 1);

  logic             locked_s;
  rst_state_e       state_q;
  logic [SCW-1:0]   cnt_q;
  logic             rst_n_q;
  logic             active_q;
  logic [CNT_W-1:0] count_q;

  pulpemu_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (ref_clk),
    .rst_i  (pad_reset),
    .d_i    (clk_locked_i),
    .q_o    (locked_s)
  );

  // Outputs are registered alongside the state so the SoC never sees decode glitches.
  always_ff @(posedge ref_clk or posedge pad_reset) begin
    if (pad_reset) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      rst_n_q  <= 1'b0;
      active_q <= 1'b1;
      count_q  <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_q <= '0;
          if (locked_s) state_q <= STRETCH;
        end
        STRETCH: begin
          if (!locked_s) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else if (soft_rst_req_i) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            rst_n_q  <= 1'b1;
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s || soft_rst_req_i) begin
            state_q  <= HOLD;
            rst_n_q  <= 1'b0;
            active_q <= 1'b1;
            if (count_q != '1) count_q <= count_q + 1'b1;
          end
        end
        default: begin
          state_q  <= HOLD;
          cnt_q    <= '0;
          rst_n_q  <= 1'b0;
          active_q <= 1'b1;
        end
      endcase
    end
  end

  assign pad_reset_n_o = rst_n_q;
  assign rst_active_o  = active_q;
  assign rst_count_o   = count_q;

endmodule
